// File: rtl/pe_pkg.sv
// Shared definitions for the PE traffic generator: NIC register map,
// packet field positions and the control FSM state encoding.
// No logic; imported by pe_pkt_build and pe_traffic_gen.
package pe_pkg;

    localparam int PKT_W = 64;

    // NIC register select values
    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

    // Packet field positions (LSB of each multi-bit field)
    localparam int PKT_VC_BIT   = 63;
    localparam int PKT_XDIR_BIT = 62;
    localparam int PKT_YDIR_BIT = 61;
    localparam int PKT_HOPX_LSB = 52;
    localparam int PKT_HOPY_LSB = 48;
    localparam int PKT_SRCX_LSB = 44;
    localparam int PKT_SRCY_LSB = 40;
    localparam int PKT_TAG_LSB  = 16;
    localparam int PKT_SEQ_LSB  = 0;

    localparam logic [15:0] PKT_TAG = 16'hC0DE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POLL_RX  = 3'd1,
        ST_READ_RX  = 3'd2,
        ST_POLL_TX  = 3'd3,
        ST_WRITE_TX = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

endpackage

// File: rtl/pe_pkt_build.sv
// Purpose: formats one outgoing packet (routing header + tagged sequence payload).
// Latency: purely combinational. Backpressure: none; output follows inputs.
// Ports: dest_x/dest_y destination coords, seq sequence number, pkt formatted packet.
module pe_pkt_build
    import pe_pkg::*;
#(
    parameter int SRC_X = 0,
    parameter int SRC_Y = 0
) (
    input  logic [1:0]       dest_x,
    input  logic [1:0]       dest_y,
    input  logic [15:0]      seq,
    output logic [PKT_W-1:0] pkt
);

    localparam logic [1:0] SX = 2'(SRC_X);
    localparam logic [1:0] SY = 2'(SRC_Y);

    logic       x_pos;
    logic       y_pos;
    logic [1:0] hop_x;
    logic [1:0] hop_y;

    // Larger minus smaller keeps the 2-bit subtraction from wrapping.
    assign x_pos = (dest_x > SX);
    assign y_pos = (dest_y > SY);
    assign hop_x = x_pos ? (dest_x - SX) : (SX - dest_x);
    assign hop_y = y_pos ? (dest_y - SY) : (SY - dest_y);

    always_comb begin
        pkt                         = '0;
        pkt[PKT_VC_BIT]             = seq[0];
        pkt[PKT_XDIR_BIT]           = x_pos;
        pkt[PKT_YDIR_BIT]           = y_pos;
        pkt[PKT_HOPX_LSB +: 4]      = {2'b00, hop_x};
        pkt[PKT_HOPY_LSB +: 4]      = {2'b00, hop_y};
        pkt[PKT_SRCX_LSB +: 4]      = {2'b00, SX};
        pkt[PKT_SRCY_LSB +: 4]      = {2'b00, SY};
        pkt[PKT_TAG_LSB +: 16]      = PKT_TAG;
        pkt[PKT_SEQ_LSB +: 16]      = seq;
    end

endmodule

// File: rtl/pe_traffic_gen.sv
// Purpose: PE stand-in that injects N packets to a fixed destination and drains all RX packets.
// Latency: one NIC access per cycle; RX read data appears on rx_data/rx_valid one cycle after the read.
// Backpressure: polls NIC output status and only writes when not full; RX polled before every TX attempt.
// Ports: clk/reset, enable + num_packets/dest_x/dest_y (run config), nic_* (NIC register bus),
//        tx_count/rx_count/rx_data/rx_valid/done (status).
module pe_traffic_gen
    import pe_pkg::*;
#(
    parameter int PACKET_WIDTH = 64,
    parameter int SRC_X        = 0,
    parameter int SRC_Y        = 0,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             num_packets,
    input  logic [1:0]              dest_x,
    input  logic [1:0]              dest_y,
    output logic [1:0]              nic_addr,
    output logic [PACKET_WIDTH-1:0] nic_d_in,
    input  logic [PACKET_WIDTH-1:0] nic_d_out,
    output logic                    nic_en,
    output logic                    nic_en_wr,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic [PACKET_WIDTH-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    done
);

    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit         USE_GAP  = (GAP_CYCLES > 0);

    state_t      state;
    state_t      state_n;
    logic [15:0] np_q;
    logic [1:0]  dx_q;
    logic [1:0]  dy_q;
    logic [7:0]  gap_cnt;
    logic        tx_done;
    logic [PKT_W-1:0] tx_pkt;

    pe_pkt_build #(
        .SRC_X (SRC_X),
        .SRC_Y (SRC_Y)
    ) u_pkt_build (
        .dest_x (dx_q),
        .dest_y (dy_q),
        .seq    (tx_count),
        .pkt    (tx_pkt)
    );

    assign tx_done = (tx_count == np_q);
    assign done    = (state != ST_IDLE) && tx_done;

    // Next state and NIC bus. Poll states issue no access once enable drops,
    // so an abort never touches the NIC again.
    always_comb begin
        state_n   = state;
        nic_en    = 1'b0;
        nic_en_wr = 1'b0;
        nic_addr  = NIC_ADDR_IN_BUF;
        nic_d_in  = '0;
        case (state)
            ST_IDLE: begin
                if (enable) state_n = ST_POLL_RX;
            end
            ST_POLL_RX: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else begin
                    nic_en   = 1'b1;
                    nic_addr = NIC_ADDR_IN_STAT;
                    state_n  = nic_d_out[0] ? ST_READ_RX : ST_POLL_TX;
                end
            end
            ST_READ_RX: begin
                nic_en   = 1'b1;
                nic_addr = NIC_ADDR_IN_BUF;
                state_n  = enable ? ST_POLL_TX : ST_IDLE;
            end
            ST_POLL_TX: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (tx_done) begin
                    state_n = ST_POLL_RX;
                end else begin
                    nic_en   = 1'b1;
                    nic_addr = NIC_ADDR_OUT_STAT;
                    state_n  = nic_d_out[0] ? ST_POLL_RX : ST_WRITE_TX;
                end
            end
            ST_WRITE_TX: begin
                nic_en    = 1'b1;
                nic_en_wr = 1'b1;
                nic_addr  = NIC_ADDR_OUT_BUF;
                nic_d_in  = tx_pkt;
                if (!enable)      state_n = ST_IDLE;
                else if (USE_GAP) state_n = ST_GAP;
                else              state_n = ST_POLL_RX;
            end
            ST_GAP: begin
                if (!enable)                  state_n = ST_IDLE;
                else if (gap_cnt == GAP_LAST) state_n = ST_POLL_RX;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            np_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            gap_cnt  <= '0;
            tx_count <= '0;
            rx_count <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Counters hold while idle and clear only on a fresh start.
                    if (enable) begin
                        np_q     <= num_packets;
                        dx_q     <= dest_x;
                        dy_q     <= dest_y;
                        tx_count <= '0;
                        rx_count <= '0;
                    end
                end
                ST_READ_RX: begin
                    rx_data  <= nic_d_out;
                    rx_count <= rx_count + 16'd1;
                    rx_valid <= 1'b1;
                end
                ST_WRITE_TX: begin
                    tx_count <= tx_count + 16'd1;
                    gap_cnt  <= '0;
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Bench for pe_traffic_gen: a behavioural NIC (RX packet array, OUT status flag),
// an access log, and directed plus randomized runs checked against a packet model.
module tb_pe_traffic_gen;

    localparam int SX  = 1;
    localparam int SY  = 2;
    localparam int GAP = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] num_packets;
    logic [1:0]  dest_x, dest_y;
    logic [1:0]  nic_addr;
    logic [63:0] nic_d_in, nic_d_out;
    logic        nic_en, nic_en_wr;
    logic [15:0] tx_count, rx_count;
    logic [63:0] rx_data;
    logic        rx_valid, done;

    always #5 clk = ~clk;

    pe_traffic_gen #(
        .PACKET_WIDTH (64),
        .SRC_X        (SX),
        .SRC_Y        (SY),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .num_packets (num_packets),
        .dest_x      (dest_x),
        .dest_y      (dest_y),
        .nic_addr    (nic_addr),
        .nic_d_in    (nic_d_in),
        .nic_d_out   (nic_d_out),
        .nic_en      (nic_en),
        .nic_en_wr   (nic_en_wr),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .done        (done)
    );

    // ---------------- NIC model ----------------
    logic        out_full = 1'b0;
    logic [63:0] rx_src [0:1023];
    int          rx_wr = 0;
    int          rx_rd = 0;

    always_comb begin
        nic_d_out = 64'h0;
        case (nic_addr)
            2'b00: nic_d_out = (rx_rd < rx_wr) ? rx_src[rx_rd[9:0]] : 64'h0;
            2'b01: nic_d_out = {63'h0, (rx_rd < rx_wr)};
            2'b11: nic_d_out = {63'h0, out_full};
            default: nic_d_out = 64'h0;
        endcase
    end

    // Pop the RX buffer at the edge on which the read is sampled.
    always @(posedge clk)
        if (nic_en && !nic_en_wr && nic_addr == 2'b00) rx_rd <= rx_rd + 1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [63:0] dat;
    } acc_t;

    acc_t        acc_q [$];
    logic [63:0] rxv_q [$];

    always @(negedge clk) begin
        if (nic_en) acc_q.push_back({nic_en_wr, nic_addr, nic_en_wr ? nic_d_in : nic_d_out});
        if (rx_valid) rxv_q.push_back(rx_data);
    end

    // ---------------- checking helpers ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_pkt(input int dx, input int dy, input int seq);
        int hx, hy;
        hx = (dx > SX) ? dx - SX : SX - dx;
        hy = (dy > SY) ? dy - SY : SY - dy;
        return (64'(seq % 2) << 63) | (64'(dx > SX) << 62) | (64'(dy > SY) << 61) |
               (64'(hx) << 52) | (64'(hy) << 48) | (64'(SX) << 44) | (64'(SY) << 40) |
               64'h0000_0000_C0DE_0000 | 64'(seq % 65536);
    endfunction

    function automatic int n_writes(input int from);
        int n = 0;
        for (int i = from; i < acc_q.size(); i++) if (acc_q[i].wr) n++;
        return n;
    endfunction

    function automatic int n_reads(input int from);
        int n = 0;
        for (int i = from; i < acc_q.size(); i++) if (!acc_q[i].wr && acc_q[i].addr == 2'b00) n++;
        return n;
    endfunction

    function automatic acc_t kth_write(input int from, input int k);
        int n = 0;
        acc_t a = '0;
        for (int i = from; i < acc_q.size(); i++)
            if (acc_q[i].wr) begin
                if (n == k) return acc_q[i];
                n++;
            end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int   base, rv_base, rs, lat, n, k, dx, dy, c, idx, snap;
        acc_t a;
        logic [1:0] kinds [$];

        reset = 1'b1; enable = 1'b1; num_packets = 16'd1; dest_x = 2'd3; dest_y = 2'd0;
        repeat (3) tick();
        chk("rst_nic_en",    64'(nic_en), 64'd0);
        chk("rst_nic_en_wr", 64'(nic_en_wr), 64'd0);
        chk("rst_nic_addr",  64'(nic_addr), 64'd0);
        chk("rst_nic_d_in",  nic_d_in, 64'd0);
        chk("rst_tx_count",  64'(tx_count), 64'd0);
        chk("rst_rx_count",  64'(rx_count), 64'd0);
        chk("rst_rx_data",   rx_data, 64'd0);
        chk("rst_rx_valid",  64'(rx_valid), 64'd0);
        chk("rst_done",      64'(done), 64'd0);
        enable = 1'b0; reset = 1'b0;
        tick();
        chk("idle_nic_en", 64'(nic_en), 64'd0);

        // Single send to (3,0)
        base = acc_q.size();
        num_packets = 16'd1; dest_x = 2'd3; dest_y = 2'd0; enable = 1'b1;
        wait_done(40, "single_done");
        repeat (6) tick();
        chk("single_nwrites", 64'(n_writes(base)), 64'd1);
        a = kth_write(base, 0);
        chk("single_addr", 64'(a.addr), 64'd2);
        chk("single_data", a.dat, model_pkt(3, 0, 0));
        chk("single_tx_count", 64'(tx_count), 64'd1);
        chk("single_rx_count", 64'(rx_count), 64'd0);
        stop_run();
        chk("held_tx_count", 64'(tx_count), 64'd1);
        chk("idle_done", 64'(done), 64'd0);

        // Backpressure: output full for 10 cycles
        base = acc_q.size();
        out_full = 1'b1;
        num_packets = 16'd1; dest_x = 2'd0; dest_y = 2'd3; enable = 1'b1;
        repeat (10) tick();
        chk("bp_no_write", 64'(n_writes(base)), 64'd0);
        chk("bp_not_done", 64'(done), 64'd0);
        out_full = 1'b0;
        lat = 0;
        while (n_writes(base) == 0 && lat < 4) begin
            tick();
            lat++;
        end
        chk("bp_write_latency", 64'(n_writes(base)), 64'd1);
        chk("bp_data", kth_write(base, 0).dat, model_pkt(0, 3, 0));
        stop_run();

        // Receive one packet, nothing to send
        rx_src[rx_wr[9:0]] = 64'h8000_0000_0000_00AB; rx_wr++;
        base = acc_q.size(); rv_base = rxv_q.size();
        num_packets = 16'd0; dest_x = 2'd1; dest_y = 2'd2; enable = 1'b1;
        tick();
        chk("zero_pkts_done", 64'(done), 64'd1);
        repeat (10) tick();
        chk("rx_nreads", 64'(n_reads(base)), 64'd1);
        chk("rx_count", 64'(rx_count), 64'd1);
        chk("rx_data", rx_data, 64'h8000_0000_0000_00AB);
        chk("rx_pulses", 64'(rxv_q.size() - rv_base), 64'd1);
        chk("rx_no_write", 64'(n_writes(base)), 64'd0);
        stop_run();

        // Simultaneous RX and TX ready
        for (int i = 0; i < 8; i++) begin
            rx_src[rx_wr[9:0]] = {$urandom, $urandom}; rx_wr++;
        end
        base = acc_q.size();
        num_packets = 16'd3; dest_x = 2'($urandom_range(0, 3)); dest_y = 2'($urandom_range(0, 3));
        enable = 1'b1;
        wait_done(120, "sim_done");
        repeat (30) tick();
        kinds.delete();
        for (int i = base; i < acc_q.size(); i++) begin
            if (acc_q[i].wr) kinds.push_back(2'd2);
            else if (acc_q[i].addr == 2'b00) kinds.push_back(2'd0);
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("sim_order_%0d", i), 64'((i < kinds.size()) ? kinds[i] : 2'd3),
                64'((i % 2 == 0) ? 2'd0 : 2'd2));
        chk("sim_tx_count", 64'(tx_count), 64'd3);
        chk("sim_rx_ge3", 64'(rx_count >= 16'd3), 64'd1);
        chk("sim_rx_match", 64'(rx_count), 64'(n_reads(base)));
        stop_run();

        // Randomized runs
        for (int it = 0; it < 4; it++) begin
            dx = $urandom_range(0, 3); dy = $urandom_range(0, 3);
            n  = $urandom_range(1, 6); k  = $urandom_range(0, 6);
            rs = rx_wr;
            for (int j = 0; j < k; j++) begin
                rx_src[rx_wr[9:0]] = {$urandom, $urandom}; rx_wr++;
            end
            base = acc_q.size(); rv_base = rxv_q.size();
            num_packets = 16'(n); dest_x = 2'(dx); dest_y = 2'(dy); enable = 1'b1;
            c = 0;
            while (!(done && rx_rd == rx_wr) && c < 2000) begin
                tick();
                out_full = ($urandom_range(0, 2) == 0);
                c++;
            end
            out_full = 1'b0;
            repeat (2) tick();
            chk($sformatf("rnd%0d_finished", it), 64'(done && rx_rd == rx_wr), 64'd1);
            chk($sformatf("rnd%0d_nwrites", it), 64'(n_writes(base)), 64'(n));
            for (int j = 0; j < n; j++)
                chk($sformatf("rnd%0d_pkt%0d", it, j), kth_write(base, j).dat, model_pkt(dx, dy, j));
            chk($sformatf("rnd%0d_tx_count", it), 64'(tx_count), 64'(n));
            chk($sformatf("rnd%0d_rx_count", it), 64'(rx_count), 64'(k));
            chk($sformatf("rnd%0d_rx_pulses", it), 64'(rxv_q.size() - rv_base), 64'(k));
            for (int j = 0; j < k; j++) begin
                idx = rv_base + j;
                chk($sformatf("rnd%0d_rx%0d", it, j),
                    (idx < rxv_q.size()) ? rxv_q[idx] : 64'hX, rx_src[10'(rs + j)]);
            end
            stop_run();
        end

        // Abort during the inter-packet gap, then restart
        base = acc_q.size();
        dx = $urandom_range(0, 3); dy = $urandom_range(0, 3);
        num_packets = 16'd3; dest_x = 2'(dx); dest_y = 2'(dy); enable = 1'b1;
        c = 0;
        while (n_writes(base) == 0 && c < 30) begin
            tick();
            c++;
        end
        chk("abort_first_write", 64'(n_writes(base)), 64'd1);
        enable = 1'b0;
        snap = acc_q.size();
        repeat (10) tick();
        chk("abort_no_access", 64'(acc_q.size()), 64'(snap));
        chk("abort_tx_held", 64'(tx_count), 64'd1);
        chk("abort_idle_done", 64'(done), 64'd0);
        chk("abort_nic_en", 64'(nic_en), 64'd0);
        base = acc_q.size();
        num_packets = 16'd2; enable = 1'b1;
        tick();
        chk("restart_tx_clear", 64'(tx_count), 64'd0);
        chk("restart_rx_clear", 64'(rx_count), 64'd0);
        wait_done(60, "restart_done");
        chk("restart_first_pkt", kth_write(base, 0).dat, model_pkt(dx, dy, 0));
        chk("restart_tx_count", 64'(tx_count), 64'd2);
        stop_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
